// File: rtl/dummy_arya_mt.sv
// Multi-thread core stand-in: per-thread IDLE/BUSY run emulation ending on count expiry, debug step edge or abort.
// Latency: start seen on an enabled edge raises thread_busy on that edge; done/aborted/last_count register on the ending edge.
// Backpressure: none; en=0 freezes every register, including pending done/aborted pulses.
module dummy_arya_mt #(
    parameter int NUM_THREADS_PER_CORE = 4,
    parameter int COUNT_WIDTH          = 10
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        en,
    input  logic [NUM_THREADS_PER_CORE-1:0]             start_thread,
    input  logic [NUM_THREADS_PER_CORE*COUNT_WIDTH-1:0] run_length,
    input  logic                                        debug_on,
    input  logic [NUM_THREADS_PER_CORE-1:0]             debug_commands,
    input  logic [NUM_THREADS_PER_CORE-1:0]             abort,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_busy,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_done,
    output logic [NUM_THREADS_PER_CORE-1:0]             thread_aborted,
    output logic [NUM_THREADS_PER_CORE*COUNT_WIDTH-1:0] last_count
);

    localparam int N  = NUM_THREADS_PER_CORE;
    localparam int CW = COUNT_WIDTH;

    // One-bit encoding so thread_busy is the state flop itself.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q [N];
    state_t          state_d [N];
    logic [CW-1:0]   cnt_q   [N];
    logic [CW-1:0]   cnt_d   [N];
    logic [CW-1:0]   len_q   [N];
    logic [CW-1:0]   len_d   [N];
    logic [CW-1:0]   last_q  [N];
    logic [CW-1:0]   last_d  [N];
    logic [CW-1:0]   rl_slice[N];
    logic [N-1:0]    done_q;
    logic [N-1:0]    done_d;
    logic [N-1:0]    abrt_q;
    logic [N-1:0]    abrt_d;
    logic [N-1:0]    cmd_prev;
    logic [N-1:0]    step;

    assign step = debug_commands & ~cmd_prev;

    for (genvar g = 0; g < N; g++) begin : g_thread_io
        assign rl_slice[g]                 = run_length[CW*g +: CW];
        assign last_count[CW*g +: CW]      = last_q[g];
        assign thread_busy[g]              = (state_q[g] == BUSY);
    end

    assign thread_done    = done_q;
    assign thread_aborted = abrt_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            len_d[i]   = len_q[i];
            last_d[i]  = last_q[i];
            done_d[i]  = 1'b0;
            abrt_d[i]  = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (start_thread[i]) begin
                        state_d[i] = BUSY;
                        cnt_d[i]   = '0;
                        // A zero length still occupies the thread for one cycle.
                        len_d[i]   = (rl_slice[i] == '0) ? CW'(1) : rl_slice[i];
                    end
                end
                BUSY: begin
                    if (abort[i]) begin
                        state_d[i] = IDLE;
                        abrt_d[i]  = 1'b1;
                        last_d[i]  = cnt_q[i] + CW'(1);
                    end else if (debug_on ? step[i] : (cnt_q[i] == len_q[i] - CW'(1))) begin
                        state_d[i] = IDLE;
                        done_d[i]  = 1'b1;
                        last_d[i]  = cnt_q[i] + CW'(1);
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                len_q[i]   <= '0;
                last_q[i]  <= '0;
            end
            done_q   <= '0;
            abrt_q   <= '0;
            cmd_prev <= '0;
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                len_q[i]   <= len_d[i];
                last_q[i]  <= last_d[i];
            end
            done_q   <= done_d;
            abrt_q   <= abrt_d;
            cmd_prev <= debug_commands;
        end
    end

endmodule

// File: tb/tb_dummy_arya_mt.sv
// Bench for dummy_arya_mt: directed runs with literal expectations plus randomized traffic against a cycle-level model.
module tb_dummy_arya_mt;

    localparam int N  = 4;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic            debug_on = 1'b0;
    logic [N-1:0]    start_thread = '0;
    logic [N-1:0]    debug_commands = '0;
    logic [N-1:0]    abort = '0;
    logic [N*CW-1:0] run_length = '0;
    logic [N-1:0]    thread_busy;
    logic [N-1:0]    thread_done;
    logic [N-1:0]    thread_aborted;
    logic [N*CW-1:0] last_count;

    dummy_arya_mt #(.NUM_THREADS_PER_CORE(N), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .start_thread   (start_thread),
        .run_length     (run_length),
        .debug_on       (debug_on),
        .debug_commands (debug_commands),
        .abort          (abort),
        .thread_busy    (thread_busy),
        .thread_done    (thread_done),
        .thread_aborted (thread_aborted),
        .last_count     (last_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks total elapsed busy cycles as an unbounded integer; the counter width only
    // enters through modulo arithmetic when comparing against the length or reporting a count.
    bit m_busy [N];
    int m_el   [N];
    int m_len  [N];
    int m_last [N];
    bit m_done [N];
    bit m_ab   [N];
    bit m_prev [N];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] <= 1'b0; m_el[i] <= 0; m_len[i] <= 0; m_last[i] <= 0;
                m_done[i] <= 1'b0; m_ab[i] <= 1'b0; m_prev[i] <= 1'b0;
            end
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] <= debug_commands[i];
                m_done[i] <= 1'b0;
                m_ab[i]   <= 1'b0;
                if (m_busy[i]) begin
                    if (abort[i]) begin
                        m_busy[i] <= 1'b0;
                        m_ab[i]   <= 1'b1;
                        m_last[i] <= (m_el[i] + 1) % (1 << CW);
                    end else if (debug_on ? (debug_commands[i] && !m_prev[i])
                                          : ((m_el[i] % (1 << CW)) == m_len[i] - 1)) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_last[i] <= (m_el[i] + 1) % (1 << CW);
                    end else begin
                        m_el[i] <= m_el[i] + 1;
                    end
                end else if (start_thread[i]) begin
                    m_busy[i] <= 1'b1;
                    m_el[i]   <= 0;
                    m_len[i]  <= (run_length[i*CW +: CW] == '0) ? 1 : int'(run_length[i*CW +: CW]);
                end
            end
        end
    end

    logic [N-1:0]    e_busy, e_done, e_ab;
    logic [N*CW-1:0] e_last;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                e_busy[i]           = m_busy[i];
                e_done[i]           = m_done[i];
                e_ab[i]             = m_ab[i];
                e_last[i*CW +: CW]  = CW'(m_last[i]);
            end
            chk("model_busy",    64'(thread_busy),    64'(e_busy));
            chk("model_done",    64'(thread_done),    64'(e_done));
            chk("model_aborted", 64'(thread_aborted), 64'(e_ab));
            chk("model_last",    64'(last_count),     64'(e_last));
        end
    end

    task automatic set_rl(input int th, input int v);
        run_length[th*CW +: CW] = CW'(v);
    endtask

    // Samples one thread for K cycles; stimulus events fire right after the sample of cycle k.
    task automatic track(input int th, input int K, input int cmd_on, input int cmd_off,
                         input int ab_on, input int en_off, input int en_on,
                         output int bc, output int dp, output int ap, output int ds,
                         output bit coinc);
        bit pb, pd, pa;
        bc = 0; dp = 0; ap = 0; ds = 0; coinc = 1'b1; pb = 1'b0; pd = 1'b0; pa = 1'b0;
        for (int k = 1; k <= K; k++) begin
            @(negedge clk);
            if (thread_busy[th]) bc++;
            if (thread_done[th]) ds++;
            if (thread_done[th] && !pd) dp++;
            if (thread_aborted[th] && !pa) ap++;
            if (pb && !thread_busy[th] && !thread_done[th] && !thread_aborted[th]) coinc = 1'b0;
            pb = thread_busy[th]; pd = thread_done[th]; pa = thread_aborted[th];
            #1;
            start_thread = '0;
            if (k == cmd_on)    debug_commands[th] = 1'b1;
            if (k == cmd_off)   debug_commands[th] = 1'b0;
            if (k == ab_on)     abort[th] = 1'b1;
            if (k == ab_on + 1) abort[th] = 1'b0;
            if (k == en_off)    en = 1'b0;
            if (k == en_on)     en = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dp, ap, ds;
        bit coinc, seen;
        int first_k [N];

        #1 reset = 1'b0;
        #2;
        chk("reset_busy",    64'(thread_busy),    64'(0));
        chk("reset_done",    64'(thread_done),    64'(0));
        chk("reset_aborted", 64'(thread_aborted), 64'(0));
        chk("reset_last",    64'(last_count),     64'(0));
        @(negedge clk); #1;
        reset = 1'b1; en = 1'b1; chk_en = 1'b1;

        // Counter mode, length 5 then length 0.
        set_rl(0, 5); start_thread[0] = 1'b1;
        track(0, 12, -1, -1, -1, -1, -1, bc, dp, ap, ds, coinc);
        chk("len5_busy_cycles", 64'(bc), 64'(5));
        chk("len5_done_pulses", 64'(dp), 64'(1));
        chk("len5_done_at_fall", 64'(coinc), 64'(1));
        chk("len5_last", 64'(last_count[CW-1:0]), 64'(5));
        set_rl(0, 0); start_thread[0] = 1'b1;
        track(0, 8, -1, -1, -1, -1, -1, bc, dp, ap, ds, coinc);
        chk("len0_busy_cycles", 64'(bc), 64'(1));
        chk("len0_last", 64'(last_count[CW-1:0]), 64'(1));

        // Debug step: command held high 10 cycles yields a single completion.
        debug_on = 1'b1; set_rl(2, 3); start_thread[2] = 1'b1;
        track(2, 20, 5, 15, -1, -1, -1, bc, dp, ap, ds, coinc);
        chk("dbg_done_pulses", 64'(dp), 64'(1));
        chk("dbg_last", 64'(last_count[2*CW +: CW]), 64'(5));
        debug_on = 1'b0;

        // Abort wins over the completion due on the same edge.
        set_rl(1, 3); start_thread[1] = 1'b1;
        track(1, 10, -1, -1, 3, -1, -1, bc, dp, ap, ds, coinc);
        chk("abort_pulses", 64'(ap), 64'(1));
        chk("abort_no_done", 64'(dp), 64'(0));
        chk("abort_last", 64'(last_count[CW +: CW]), 64'(3));
        abort[1] = 1'b1;
        track(1, 4, -1, -1, -1, -1, -1, bc, dp, ap, ds, coinc);
        abort[1] = 1'b0;
        chk("idle_abort_ignored", 64'(ap + bc), 64'(0));
        chk("idle_abort_last", 64'(last_count[CW +: CW]), 64'(3));

        // Enable gating stretches busy and holds a done pulse.
        set_rl(0, 4); start_thread[0] = 1'b1;
        track(0, 14, -1, -1, -1, 2, 5, bc, dp, ap, ds, coinc);
        chk("en_busy_cycles", 64'(bc), 64'(7));
        chk("en_last", 64'(last_count[CW-1:0]), 64'(4));
        set_rl(0, 2); start_thread[0] = 1'b1;
        track(0, 10, -1, -1, -1, 3, 5, bc, dp, ap, ds, coinc);
        chk("en_done_held_cycles", 64'(ds), 64'(3));
        chk("en_done_pulses", 64'(dp), 64'(1));

        // All threads together, staggered completions.
        for (int i = 0; i < N; i++) begin
            set_rl(i, i + 2); first_k[i] = 0;
        end
        start_thread = '1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (thread_done[i] && first_k[i] == 0) first_k[i] = k;
            #1 start_thread = '0;
        end
        for (int i = 0; i < N; i++) chk($sformatf("multi_done_cycle_t%0d", i), 64'(first_k[i]), 64'(i + 3));

        // Asynchronous reset mid-run.
        for (int i = 0; i < N; i++) set_rl(i, 8);
        start_thread = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1 start_thread = '0;
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",    64'(thread_busy),    64'(0));
        chk("arst_done",    64'(thread_done),    64'(0));
        chk("arst_aborted", 64'(thread_aborted), 64'(0));
        chk("arst_last",    64'(last_count),     64'(0));
        @(negedge clk); #1 reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if ((thread_busy | thread_done | thread_aborted) != '0) seen = 1'b1;
        end
        chk("post_reset_quiet", 64'(seen), 64'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            reset          = (c == 1500) ? 1'b0 : 1'b1;
            start_thread   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                abort[i] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 3) == 0) debug_commands[i] = ~debug_commands[i];
                set_rl(i, $urandom_range(0, 12));
            end
            if ($urandom_range(0, 99) == 0) debug_on = ~debug_on;
            en = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
